relu_maxpool: RTL and testbench

Streaming ReLU plus 2×2/stride-2 max-pool stage placed directly downstream of the convolution top level. It consumes the valid-qualified raster stream of the (N−K_SIZE+1)² feature map, including idle gaps where valid is low. It emits one pooled pixel per 2×2 window on a valid-qualified output stream and signals frame completion. It shares the convolver's parameter set, so it is instantiated with the same N and K_SIZE.

---
 rtl/conv_pkg.sv | 22 ++
 rtl/relu_maxpool_line_buf.sv | 39 +++
 rtl/relu_maxpool.sv | 136 +++++++++++++
 tb/tb_relu_maxpool.sv | 249 ++++++++++++++++++++++++
 4 files changed

// File: rtl/conv_pkg.sv
// Parameter defaults and helpers shared by the convolver and the ReLU/max-pool stage.
package conv_pkg;

  localparam int unsigned CONV_N          = 4;
  localparam int unsigned CONV_K_SIZE     = 3;
  localparam int unsigned CONV_DATA_WIDTH = 16;
  localparam int unsigned CONV_Q          = 5;

  // Feature-map side and pooled side for the default convolver configuration.
  localparam int unsigned M = CONV_N - CONV_K_SIZE + 1;
  localparam int unsigned P = M / 2;

  typedef enum logic {
    IDLE,
    RUN
  } pool_state_e;

  function automatic logic [CONV_DATA_WIDTH-1:0] relu(input logic [CONV_DATA_WIDTH-1:0] x);
    return x[CONV_DATA_WIDTH-1] ? '0 : x;
  endfunction

endpackage

// File: rtl/relu_maxpool_line_buf.sv
// One-row buffer of horizontal pair maxima (pool_line_buf): sync write, comb read, reset-clear.
module pool_line_buf
  import conv_pkg::*;
#(
  parameter int unsigned DEPTH      = P,
  parameter int unsigned DATA_WIDTH = CONV_DATA_WIDTH,
  parameter int unsigned IDX_W      = (DEPTH > 1) ? $clog2(DEPTH) : 1
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  we_i,
  input  logic [IDX_W-1:0]      idx_i,
  input  logic [DATA_WIDTH-1:0] wdata_i,
  output logic [DATA_WIDTH-1:0] rdata_o
);

  logic [DATA_WIDTH-1:0] mem_q [DEPTH];
  logic [DATA_WIDTH-1:0] mem_d [DEPTH];

  always_comb begin
    mem_d = mem_q;
    if (we_i) begin
      mem_d[idx_i] = wdata_i;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      for (int unsigned i = 0; i < DEPTH; i++) begin
        mem_q[i] <= '0;
      end
    end else begin
      mem_q <= mem_d;
    end
  end

  assign rdata_o = mem_q[idx_i];

endmodule

// File: rtl/relu_maxpool.sv
// Streaming ReLU followed by 2x2 / stride-2 max-pool over the convolver's raster output.
module relu_maxpool
  import conv_pkg::*;
#(
  parameter int unsigned N          = CONV_N,
  parameter int unsigned DATA_WIDTH = CONV_DATA_WIDTH,
  parameter int unsigned Q          = CONV_Q,
  parameter int unsigned K_SIZE     = CONV_K_SIZE
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  start,
  input  logic [DATA_WIDTH-1:0] data_i,
  input  logic                  valid_i,
  output logic [DATA_WIDTH-1:0] data_o,
  output logic                  valid_o,
  output logic                  done_o,
  output logic                  busy_o
);

  localparam int unsigned M  = N - K_SIZE + 1;
  localparam int unsigned P  = M / 2;
  localparam int unsigned CW = (M > 1) ? $clog2(M) : 1;
  localparam int unsigned IW = (P > 1) ? $clog2(P) : 1;

  if ((M % 2 != 0) || (M < 2)) begin : g_bad_m
    $error("relu_maxpool: feature-map side must be even and at least 2");
  end
  if (Q >= DATA_WIDTH) begin : g_bad_q
    $error("relu_maxpool: fractional bits must be fewer than DATA_WIDTH");
  end

  pool_state_e           state_q, state_d;
  logic [CW-1:0]         col_q, col_d, row_q, row_d;
  logic [DATA_WIDTH-1:0] hold_q, hold_d;
  logic [DATA_WIDTH-1:0] data_q, data_d;
  logic                  valid_q, valid_d;
  logic                  done_q, done_d;

  logic [CW-1:0]         col_cur, row_cur;
  logic [DATA_WIDTH-1:0] r, pair, pooled, lb_rdata;
  logic [IW-1:0]         lb_idx;
  logic                  lb_we, accept;

  pool_line_buf #(
    .DEPTH      (P),
    .DATA_WIDTH (DATA_WIDTH),
    .IDX_W      (IW)
  ) u_line_buf (
    .clk     (clk),
    .rst     (rst),
    .we_i    (lb_we),
    .idx_i   (lb_idx),
    .wdata_i (pair),
    .rdata_o (lb_rdata)
  );

  always_comb begin
    state_d = state_q;
    col_d   = col_q;
    row_d   = row_q;
    hold_d  = hold_q;
    data_d  = data_q;
    valid_d = 1'b0;
    done_d  = 1'b0;
    lb_we   = 1'b0;

    // A start beat is pixel (0,0) of the new frame, so it sees cleared counters.
    col_cur = start ? '0 : col_q;
    row_cur = start ? '0 : row_q;
    lb_idx  = IW'(col_cur >> 1);

    // After ReLU both operands are non-negative, so unsigned compares suffice.
    r      = data_i[DATA_WIDTH-1] ? '0 : data_i;
    pair   = (r > hold_q) ? r : hold_q;
    pooled = (lb_rdata > pair) ? lb_rdata : pair;
    accept = valid_i && ((state_q == RUN) || start);

    if (start) begin
      state_d = RUN;
      col_d   = '0;
      row_d   = '0;
    end

    if (accept) begin
      if (!col_cur[0]) begin
        hold_d = r;
      end else if (!row_cur[0]) begin
        lb_we = 1'b1;
      end else begin
        valid_d = 1'b1;
        data_d  = pooled;
      end

      if (col_cur == CW'(M - 1)) begin
        col_d = '0;
        if (row_cur == CW'(M - 1)) begin
          row_d   = '0;
          done_d  = 1'b1;
          state_d = IDLE;
        end else begin
          row_d = row_cur + 1'b1;
        end
      end else begin
        col_d = col_cur + 1'b1;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= IDLE;
      col_q   <= '0;
      row_q   <= '0;
      hold_q  <= '0;
      data_q  <= '0;
      valid_q <= 1'b0;
      done_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      col_q   <= col_d;
      row_q   <= row_d;
      hold_q  <= hold_d;
      data_q  <= data_d;
      valid_q <= valid_d;
      done_q  <= done_d;
    end
  end

  assign data_o  = data_q;
  assign valid_o = valid_q;
  assign done_o  = done_q;
  // The FSM is already back in IDLE on the done cycle; keep busy up through it.
  assign busy_o  = (state_q == RUN) || done_q;

endmodule

// File: tb/tb_relu_maxpool.sv
// Directed bench for relu_maxpool at N=6, K_SIZE=3 (4x4 feature map, 2x2 pooled).
module tb_relu_maxpool;

  typedef logic [15:0] frame_t [16];

  logic        clk = 1'b0;
  logic        rst;
  logic        start;
  logic [15:0] data_i;
  logic        valid_i;
  logic [15:0] data_o;
  logic        valid_o;
  logic        done_o;
  logic        busy_o;

  int n_checks = 0;
  int n_fail   = 0;

  logic        obs_v    [16];
  logic        obs_done [16];
  logic        obs_busy [16];
  logic [15:0] obs_d    [16];
  int          gap_hits;

  always #5 clk = ~clk;

  relu_maxpool #(
    .N          (6),
    .DATA_WIDTH (16),
    .Q          (5),
    .K_SIZE     (3)
  ) dut (
    .clk     (clk),
    .rst     (rst),
    .start   (start),
    .data_i  (data_i),
    .valid_i (valid_i),
    .data_o  (data_o),
    .valid_o (valid_o),
    .done_o  (done_o),
    .busy_o  (busy_o)
  );

  // Drives 16 beats (optionally with start on beat 0 and idle gaps after each)
  // and records what the outputs show one cycle after each accepting edge.
  task automatic run_frame(input frame_t vals, input int gap, input bit with_start);
    gap_hits = 0;
    for (int i = 0; i < 16; i++) begin
      data_i  = vals[i];
      valid_i = 1'b1;
      start   = with_start && (i == 0);
      @(posedge clk);
      #1;
      start       = 1'b0;
      valid_i     = 1'b0;
      obs_v[i]    = valid_o;
      obs_d[i]    = data_o;
      obs_done[i] = done_o;
      obs_busy[i] = busy_o;
      for (int g = 0; g < gap; g++) begin
        @(posedge clk);
        #1;
        if (valid_o || done_o) gap_hits++;
      end
    end
  endtask

  task automatic test_reset();
    rst = 1'b1; start = 1'b0; valid_i = 1'b0; data_i = '0;
    repeat (2) @(posedge clk);
    #1;
    n_checks++; if (data_o !== 16'h0000) begin n_fail++; $display("FAIL reset_data got %h want 0000", data_o); end
    n_checks++; if (valid_o !== 1'b0) begin n_fail++; $display("FAIL reset_valid got %b want 0", valid_o); end
    n_checks++; if (done_o !== 1'b0) begin n_fail++; $display("FAIL reset_done got %b want 0", done_o); end
    n_checks++; if (busy_o !== 1'b0) begin n_fail++; $display("FAIL reset_busy got %b want 0", busy_o); end
    rst = 1'b0;
    @(posedge clk);
    #1;
  endtask

  task automatic test_basic(input string tag);
    frame_t      vals;
    logic [15:0] exp_out [4];
    int          k;
    for (int i = 0; i < 16; i++) vals[i] = 16'(i + 1);
    exp_out[0] = 16'd6; exp_out[1] = 16'd8; exp_out[2] = 16'd14; exp_out[3] = 16'd16;
    run_frame(vals, 0, 1'b1);
    k = 0;
    for (int i = 0; i < 16; i++) begin
      logic ev;
      ev = (i == 5) || (i == 7) || (i == 13) || (i == 15);
      n_checks++; if (obs_v[i] !== ev) begin n_fail++; $display("FAIL %s_valid beat %0d got %b want %b", tag, i, obs_v[i], ev); end
      n_checks++; if (obs_done[i] !== (i == 15)) begin n_fail++; $display("FAIL %s_done beat %0d got %b want %b", tag, i, obs_done[i], (i == 15)); end
      n_checks++; if (obs_busy[i] !== 1'b1) begin n_fail++; $display("FAIL %s_busy beat %0d got %b want 1", tag, i, obs_busy[i]); end
      if (ev) begin
        n_checks++; if (obs_d[i] !== exp_out[k]) begin n_fail++; $display("FAIL %s_data out %0d got %h want %h", tag, k, obs_d[i], exp_out[k]); end
        k++;
      end
    end
    @(posedge clk);
    #1;
    n_checks++; if (busy_o !== 1'b0) begin n_fail++; $display("FAIL %s_busy_after got %b want 0", tag, busy_o); end
    n_checks++; if (valid_o !== 1'b0) begin n_fail++; $display("FAIL %s_valid_after got %b want 0", tag, valid_o); end
  endtask

  task automatic test_negated();
    frame_t vals;
    for (int i = 0; i < 16; i++) vals[i] = -16'(i + 1);
    run_frame(vals, 0, 1'b1);
    for (int i = 0; i < 16; i++) begin
      logic ev;
      ev = (i == 5) || (i == 7) || (i == 13) || (i == 15);
      n_checks++; if (obs_v[i] !== ev) begin n_fail++; $display("FAIL neg_valid beat %0d got %b want %b", i, obs_v[i], ev); end
      if (ev) begin
        n_checks++; if (obs_d[i] !== 16'h0000) begin n_fail++; $display("FAIL neg_data beat %0d got %h want 0000", i, obs_d[i]); end
      end
    end
    n_checks++; if (obs_done[15] !== 1'b1) begin n_fail++; $display("FAIL neg_done got %b want 1", obs_done[15]); end
  endtask

  task automatic test_mixed_extremes();
    frame_t      vals;
    logic [15:0] exp_out [4];
    int          k;
    vals[0]  = -16'd3;   vals[1]  = -16'd1;   vals[2]  = 16'd1;     vals[3]  = 16'd0;
    vals[4]  = -16'd7;   vals[5]  = 16'd2;    vals[6]  = 16'd0;     vals[7]  = 16'd5;
    vals[8]  = 16'h7FFF; vals[9]  = 16'h8000; vals[10] = 16'h8000;  vals[11] = 16'h8000;
    vals[12] = 16'h8000; vals[13] = 16'h8000; vals[14] = 16'h8000;  vals[15] = 16'd3;
    exp_out[0] = 16'd2; exp_out[1] = 16'd5; exp_out[2] = 16'h7FFF; exp_out[3] = 16'd3;
    run_frame(vals, 0, 1'b1);
    k = 0;
    for (int i = 0; i < 16; i++) begin
      if ((i == 5) || (i == 7) || (i == 13) || (i == 15)) begin
        n_checks++; if (obs_v[i] !== 1'b1) begin n_fail++; $display("FAIL mixed_valid beat %0d got %b want 1", i, obs_v[i]); end
        n_checks++; if (obs_d[i] !== exp_out[k]) begin n_fail++; $display("FAIL mixed_data out %0d got %h want %h", k, obs_d[i], exp_out[k]); end
        k++;
      end
    end
  endtask

  task automatic test_gaps();
    frame_t      vals;
    logic [15:0] exp_out [4];
    int          k;
    for (int i = 0; i < 16; i++) vals[i] = 16'(i + 1);
    exp_out[0] = 16'd6; exp_out[1] = 16'd8; exp_out[2] = 16'd14; exp_out[3] = 16'd16;
    run_frame(vals, 3, 1'b1);
    k = 0;
    for (int i = 0; i < 16; i++) begin
      logic ev;
      ev = (i == 5) || (i == 7) || (i == 13) || (i == 15);
      n_checks++; if (obs_v[i] !== ev) begin n_fail++; $display("FAIL gap_valid beat %0d got %b want %b", i, obs_v[i], ev); end
      if (ev) begin
        n_checks++; if (obs_d[i] !== exp_out[k]) begin n_fail++; $display("FAIL gap_data out %0d got %h want %h", k, obs_d[i], exp_out[k]); end
        k++;
      end
    end
    n_checks++; if (obs_done[15] !== 1'b1) begin n_fail++; $display("FAIL gap_done got %b want 1", obs_done[15]); end
    n_checks++; if (gap_hits !== 0) begin n_fail++; $display("FAIL gap_idle_outputs got %0d want 0", gap_hits); end
  endtask

  task automatic test_abort();
    frame_t vals;
    int     stray;
    stray = 0;
    for (int i = 0; i < 5; i++) begin
      data_i  = 16'(100 + i);
      valid_i = 1'b1;
      start   = (i == 0);
      @(posedge clk);
      #1;
      start   = 1'b0;
      valid_i = 1'b0;
      if (valid_o || done_o) stray++;
    end
    start = 1'b1;
    @(posedge clk);
    #1;
    start = 1'b0;
    if (valid_o || done_o) stray++;
    n_checks++; if (busy_o !== 1'b1) begin n_fail++; $display("FAIL abort_busy got %b want 1", busy_o); end
    for (int i = 0; i < 16; i++) vals[i] = 16'h0010;
    run_frame(vals, 0, 1'b0);
    for (int i = 0; i < 16; i++) begin
      logic ev;
      ev = (i == 5) || (i == 7) || (i == 13) || (i == 15);
      if (obs_v[i] && !ev) stray++;
      if (ev) begin
        n_checks++; if (obs_v[i] !== 1'b1 || obs_d[i] !== 16'h0010) begin n_fail++; $display("FAIL abort_data beat %0d got v=%b %h want v=1 0010", i, obs_v[i], obs_d[i]); end
      end
    end
    n_checks++; if (obs_done[15] !== 1'b1) begin n_fail++; $display("FAIL abort_done got %b want 1", obs_done[15]); end
    n_checks++; if (stray !== 0) begin n_fail++; $display("FAIL abort_stray got %0d want 0", stray); end
  endtask

  task automatic test_mid_reset();
    int stray;
    stray = 0;
    for (int i = 0; i < 9; i++) begin
      data_i  = 16'(i + 1);
      valid_i = 1'b1;
      start   = (i == 0);
      @(posedge clk);
      #1;
      start   = 1'b0;
      valid_i = 1'b0;
      if (i == 5) begin
        n_checks++; if (valid_o !== 1'b1 || data_o !== 16'd6) begin n_fail++; $display("FAIL midrst_pre got v=%b %h want v=1 0006", valid_o, data_o); end
      end
    end
    rst = 1'b1;
    @(posedge clk);
    #1;
    rst = 1'b0;
    n_checks++; if (data_o !== 16'h0000) begin n_fail++; $display("FAIL midrst_data got %h want 0000", data_o); end
    n_checks++; if (valid_o !== 1'b0) begin n_fail++; $display("FAIL midrst_valid got %b want 0", valid_o); end
    n_checks++; if (done_o !== 1'b0) begin n_fail++; $display("FAIL midrst_done got %b want 0", done_o); end
    n_checks++; if (busy_o !== 1'b0) begin n_fail++; $display("FAIL midrst_busy got %b want 0", busy_o); end
    for (int i = 0; i < 16; i++) begin
      data_i  = 16'h0100;
      valid_i = 1'b1;
      @(posedge clk);
      #1;
      valid_i = 1'b0;
      if (valid_o || done_o || busy_o) stray++;
    end
    n_checks++; if (stray !== 0) begin n_fail++; $display("FAIL idle_ignore got %0d want 0", stray); end
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog expired");
    $fatal(1, "watchdog");
  end

  initial begin
    test_reset();
    test_basic("basic");
    test_negated();
    test_mixed_extremes();
    test_gaps();
    test_abort();
    test_mid_reset();
    test_basic("recover");
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
